// File: rtl/program_load_sequencer.sv
// Boot/run controller: streams a program into the core's memory while holding it in reset,
// then releases the core for a programmed number of cycles and captures its final alu_result.
module program_load_sequencer #(
  parameter int ADD_WIDTH  = 7,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADD_WIDTH-1:0]  load_len,
  input  logic [CNT_WIDTH-1:0]  run_cycles,
  input  logic [DATA_WIDTH-1:0] byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  pm_wr_en,
  output logic [ADD_WIDTH-1:0]  pm_addr,
  output logic [DATA_WIDTH-1:0] pm_wr_data,
  output logic                  cpu_rst,
  input  logic [DATA_WIDTH-1:0] alu_result_in,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [ADD_WIDTH-1:0] ONE_A = ADD_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] ONE_C = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] ZERO_C = '0;

  state_t                state_q, state_d;
  logic [ADD_WIDTH-1:0]  count_q, count_d;
  logic [ADD_WIDTH-1:0]  len_q, len_d;
  logic [CNT_WIDTH-1:0]  run_len_q, run_len_d;
  logic [CNT_WIDTH-1:0]  run_cnt_q, run_cnt_d;
  logic                  pm_wr_en_q, pm_wr_en_d;
  logic [ADD_WIDTH-1:0]  pm_addr_q, pm_addr_d;
  logic [DATA_WIDTH-1:0] pm_wr_data_q, pm_wr_data_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;

  logic                  handshake;
  logic [ADD_WIDTH-1:0]  last_idx;
  logic                  accept_start;

  // A latched length of 0 wraps to the top address, giving a full-depth load.
  assign last_idx     = len_q - ONE_A;
  assign handshake    = (state_q == S_LOAD) && byte_valid;
  assign accept_start = start && !abort;

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    len_d        = len_q;
    run_len_d    = run_len_q;
    run_cnt_d    = run_cnt_q;
    pm_wr_en_d   = 1'b0;
    pm_addr_d    = pm_addr_q;
    pm_wr_data_d = pm_wr_data_q;
    result_d     = result_q;

    if (handshake) begin
      pm_wr_en_d   = 1'b1;
      pm_addr_d    = count_q;
      pm_wr_data_d = byte_in;
      count_d      = count_q + ONE_A;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept_start) begin
          state_d   = S_LOAD;
          len_d     = load_len;
          run_len_d = run_cycles;
          count_d   = '0;
        end
      end
      S_LOAD: begin
        if (handshake && (count_q == last_idx)) begin
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        state_d   = S_RUN;
        run_cnt_d = run_len_q;
      end
      S_RUN: begin
        // A zero count never reaches 1, so the core free-runs until abort.
        if (run_cnt_q == ONE_C) begin
          result_d  = alu_result_in;
          run_cnt_d = ZERO_C;
          state_d   = S_DONE;
        end else if (run_cnt_q != ZERO_C) begin
          run_cnt_d = run_cnt_q - ONE_C;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The write already scheduled above still goes out; only control is unwound.
    if (abort) begin
      state_d  = S_IDLE;
      count_d  = '0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      len_q        <= '0;
      run_len_q    <= '0;
      run_cnt_q    <= '0;
      pm_wr_en_q   <= 1'b0;
      pm_addr_q    <= '0;
      pm_wr_data_q <= '0;
      result_q     <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      len_q        <= len_d;
      run_len_q    <= run_len_d;
      run_cnt_q    <= run_cnt_d;
      pm_wr_en_q   <= pm_wr_en_d;
      pm_addr_q    <= pm_addr_d;
      pm_wr_data_q <= pm_wr_data_d;
      result_q     <= result_d;
    end
  end

  assign byte_ready = (state_q == S_LOAD);
  assign cpu_rst    = (state_q != S_RUN);
  assign busy       = (state_q == S_LOAD) || (state_q == S_SETTLE) || (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
  assign pm_wr_en   = pm_wr_en_q;
  assign pm_addr    = pm_addr_q;
  assign pm_wr_data = pm_wr_data_q;
  assign result     = result_q;

endmodule

// File: tb/tb_program_load_sequencer.sv
// Bench for program_load_sequencer: directed jobs with random bytes, gaps and alu values,
// judged against a memory-image / cycle-count model of a load-then-run job.
module tb_program_load_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, abort, byte_valid;
  logic [6:0] load_len;
  logic [7:0] run_cycles, byte_in, alu_result_in;
  logic       byte_ready, pm_wr_en, cpu_rst, busy, done;
  logic [6:0] pm_addr;
  logic [7:0] pm_wr_data, result;

  int tests = 0;
  int fails = 0;

  program_load_sequencer #(.ADD_WIDTH(7), .DATA_WIDTH(8), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .load_len(load_len), .run_cycles(run_cycles),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .pm_wr_en(pm_wr_en), .pm_addr(pm_addr), .pm_wr_data(pm_wr_data),
    .cpu_rst(cpu_rst), .alu_result_in(alu_result_in), .result(result),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Observer: logs every memory write and every cycle the core is out of reset.
  logic [6:0] log_addr [4096];
  logic [7:0] log_data [4096];
  int         n_wr = 0;
  int         n_low = 0;
  int         cyc = 0;
  int         last_wr_cyc = 0;
  int         low_start_cyc = 0;
  logic       prev_rst_hi = 1'b1;
  logic [7:0] last_alu = 8'h00;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (pm_wr_en) begin
      if (n_wr < 4096) begin
        log_addr[n_wr] <= pm_addr;
        log_data[n_wr] <= pm_wr_data;
      end
      n_wr        <= n_wr + 1;
      last_wr_cyc <= cyc;
    end
    if (!cpu_rst) begin
      n_low    <= n_low + 1;
      last_alu <= alu_result_in;
      if (prev_rst_hi) low_start_cyc <= cyc;
    end
    prev_rst_hi <= cpu_rst;
  end

  logic [7:0] exp_bytes [128];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    alu_result_in = 8'($urandom);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_byte_ready"}, {31'd0, byte_ready}, 32'd0);
    check({tag, "_pm_wr_en"},   {31'd0, pm_wr_en},   32'd0);
    check({tag, "_pm_addr"},    {25'd0, pm_addr},    32'd0);
    check({tag, "_pm_wr_data"}, {24'd0, pm_wr_data}, 32'd0);
    check({tag, "_cpu_rst"},    {31'd0, cpu_rst},    32'd1);
    check({tag, "_result"},     {24'd0, result},     32'd0);
    check({tag, "_busy"},       {31'd0, busy},       32'd0);
    check({tag, "_done"},       {31'd0, done},       32'd0);
  endtask

  // gaps: 0 = back-to-back, 1 = one idle cycle between bytes, 2 = random 0..2 idle cycles.
  task automatic run_job(input string tag, input int len, input int run, input int gaps,
                         input bit wait_done);
    int n;
    int wr0;
    int low0;
    int not_ready;
    int bad;
    int k;
    n         = (len == 0) ? 128 : len;
    wr0       = n_wr;
    low0      = n_low;
    not_ready = 0;
    start      = 1'b1;
    load_len   = 7'(len);
    run_cycles = 8'(run);
    step();
    start = 1'b0;
    check({tag, "_busy_load"}, {31'd0, busy}, 32'd1);
    for (int i = 0; i < n; i++) begin
      if (i != 0 && gaps == 1) begin
        byte_valid = 1'b0;
        step();
      end else if (gaps == 2) begin
        repeat ($urandom_range(0, 2)) begin
          byte_valid = 1'b0;
          byte_in    = 8'($urandom);
          step();
        end
      end
      byte_valid = 1'b1;
      byte_in    = exp_bytes[i];
      if (!byte_ready) not_ready++;
      step();
    end
    byte_valid = 1'b0;
    check({tag, "_ready_each_byte"}, not_ready, 0);
    if (wait_done) begin
      k = 0;
      while (!done && k < run + 20) begin
        byte_valid = 1'($urandom);
        byte_in    = 8'($urandom);
        step();
        k++;
      end
      byte_valid = 1'b0;
      check({tag, "_done_reached"}, {31'd0, done}, 32'd1);
      check({tag, "_write_count"}, n_wr - wr0, n);
      bad = 0;
      for (int i = 0; i < n; i++) begin
        if (log_addr[wr0 + i] !== 7'(i) || log_data[wr0 + i] !== exp_bytes[i]) bad++;
      end
      check({tag, "_mem_image"}, bad, 0);
      check({tag, "_run_len"}, n_low - low0, run);
      check({tag, "_settle_gap"}, low_start_cyc - last_wr_cyc, 1);
      check({tag, "_result"}, {24'd0, result}, {24'd0, last_alu});
      check({tag, "_cpu_rst_done"}, {31'd0, cpu_rst}, 32'd1);
      check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    int w0;
    int l0;
    logic [7:0] r0;

    rst = 1'b1; start = 1'b0; abort = 1'b0; byte_valid = 1'b0;
    load_len = '0; run_cycles = '0; byte_in = '0; alu_result_in = '0;
    step();
    step();
    check_reset_outputs("reset");
    rst = 1'b0;
    step();

    exp_bytes[0] = 8'h13; exp_bytes[1] = 8'h05; exp_bytes[2] = 8'h50; exp_bytes[3] = 8'h00;
    run_job("basic", 4, 10, 0, 1'b1);
    run_job("gapped", 4, 10, 1, 1'b1);

    for (int i = 0; i < 128; i++) exp_bytes[i] = 8'($urandom);
    run_job("full", 0, 3, 0, 1'b1);
    check("full_last_addr", {25'd0, log_addr[n_wr - 1]}, 32'd127);

    for (int j = 0; j < 3; j++) begin
      for (int i = 0; i < 128; i++) exp_bytes[i] = 8'($urandom);
      run_job("rand", $urandom_range(1, 20), $urandom_range(1, 30), 2, 1'b1);
    end

    // Free run: zero run count keeps the core going until abort.
    run_job("free", 5, 0, 0, 1'b0);
    step();
    r0 = result;
    l0 = n_low;
    repeat (520) step();
    check("free_low_cycles", n_low - l0, 520);
    check("free_cpu_rst", {31'd0, cpu_rst}, 32'd0);
    check("free_result_held", {24'd0, result}, {24'd0, r0});
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("free_abort_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("free_abort_busy", {31'd0, busy}, 32'd0);
    check("free_abort_done", {31'd0, done}, 32'd0);
    check("free_abort_result", {24'd0, result}, {24'd0, r0});

    // Abort on the second handshake; its write must still land.
    start = 1'b1; load_len = 7'd8; run_cycles = 8'd5;
    step();
    start = 1'b0;
    w0 = n_wr;
    byte_valid = 1'b1; byte_in = 8'hA5;
    step();
    byte_in = 8'h3C; abort = 1'b1;
    step();
    abort = 1'b0; byte_valid = 1'b0;
    check("abort_byte_ready", {31'd0, byte_ready}, 32'd0);
    check("abort_wr_en", {31'd0, pm_wr_en}, 32'd1);
    check("abort_wr_addr", {25'd0, pm_addr}, 32'd1);
    check("abort_wr_data", {24'd0, pm_wr_data}, 32'h3C);
    check("abort_busy", {31'd0, busy}, 32'd0);
    step();
    check("abort_wr_en_after", {31'd0, pm_wr_en}, 32'd0);
    check("abort_write_count", n_wr - w0, 2);
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", {31'd0, busy}, 32'd0);
    check("start_abort_ready", {31'd0, byte_ready}, 32'd0);
    w0 = n_wr;
    byte_valid = 1'b1;
    repeat (4) begin
      byte_in = 8'($urandom);
      step();
    end
    byte_valid = 1'b0;
    step();
    check("idle_valid_ignored", n_wr - w0, 0);

    for (int i = 0; i < 128; i++) exp_bytes[i] = 8'($urandom);
    run_job("post_abort", $urandom_range(2, 12), $urandom_range(1, 15), 2, 1'b1);

    // Reset in the middle of RUN.
    run_job("rst_run", 6, 60, 2, 1'b0);
    repeat (20) step();
    check("rst_run_mid_cpu_rst", {31'd0, cpu_rst}, 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_outputs("rst_run");
    step();
    for (int i = 0; i < 128; i++) exp_bytes[i] = 8'($urandom);
    run_job("post_rst", $urandom_range(2, 12), $urandom_range(1, 15), 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
